// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - writeback request, scoreboard and register-file write bundle (REGFILE_WB_FWD_EN adds forwarding)
`timescale 1ns/1ps
interface regfile_wb_scheduler_if #(
    parameter int XLEN = 64,
    parameter int REGW = 5
);
    logic            alu_valid;
    logic [REGW-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [REGW-1:0] mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            issue_valid;
    logic [REGW-1:0] issue_rd;
    logic            flush;
    logic [REGW-1:0] chk_rs1;
    logic [REGW-1:0] chk_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_wr_en;
    logic [REGW-1:0] rf_destn_reg;
    logic [XLEN-1:0] rf_destn_data;
`ifdef REGFILE_WB_FWD_EN
    logic            fwd_rs1_hit;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_rs1_data;
    logic [XLEN-1:0] fwd_rs2_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, flush, chk_rs1, chk_rs2,
        input  alu_ready, mem_ready, rs1_busy, rs2_busy,
        input  rf_wr_en, rf_destn_reg, rf_destn_data
`ifdef REGFILE_WB_FWD_EN
        , input fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, flush, chk_rs1, chk_rs2,
        output alu_ready, mem_ready, rs1_busy, rs2_busy,
        output rf_wr_en, rf_destn_reg, rf_destn_data
`ifdef REGFILE_WB_FWD_EN
        , output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
`endif
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin ALU/MEM writeback arbiter with RAW scoreboard (optional REGFILE_WB_FWD_EN)
`timescale 1ns/1ps
module regfile_wb_scheduler #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int REGW = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    regfile_wb_scheduler_if.slave bus
);
    typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_e;

    rr_e             rr_last_q, rr_last_d;
    logic            alu_grant, mem_grant, acc;
    logic [REGW-1:0] acc_rd;
    logic [XLEN-1:0] acc_data;
    logic            wen_q, wen_d;
    logic [REGW-1:0] reg_q, reg_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            rs1_stage, rs2_stage;

    // Nothing is granted while reset is held, so no request is lost to the reset.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        rr_last_d = rr_last_q;
        if (reset_i) begin
            if (bus.alu_valid && (!bus.mem_valid || rr_last_q == RR_MEM))
                alu_grant = 1'b1;
            else if (bus.mem_valid)
                mem_grant = 1'b1;
        end
        if (alu_grant)
            rr_last_d = RR_ALU;
        else if (mem_grant)
            rr_last_d = RR_MEM;
    end

    assign acc      = alu_grant | mem_grant;
    assign acc_rd   = alu_grant ? bus.alu_rd : bus.mem_rd;
    assign acc_data = alu_grant ? bus.alu_data : bus.mem_data;

    always_comb begin
        wen_d  = acc && (acc_rd != '0);
        reg_d  = acc ? acc_rd : reg_q;
        data_d = acc ? acc_data : data_q;
    end

    // Issue is applied after the writeback clear so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (acc)
            busy_d[acc_rd] = 1'b0;
        if (bus.flush)
            busy_d = '0;
        else if (bus.issue_valid)
            busy_d[bus.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rr_last_q <= RR_MEM;
            wen_q     <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            busy_q    <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wen_q     <= wen_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.alu_ready     = alu_grant;
    assign bus.mem_ready     = mem_grant;
    assign bus.rf_wr_en      = wen_q;
    assign bus.rf_destn_reg  = reg_q;
    assign bus.rf_destn_data = data_q;

    assign rs1_stage = wen_q && (reg_q == bus.chk_rs1) && (bus.chk_rs1 != '0);
    assign rs2_stage = wen_q && (reg_q == bus.chk_rs2) && (bus.chk_rs2 != '0);

`ifdef REGFILE_WB_FWD_EN
    assign bus.rs1_busy     = busy_q[bus.chk_rs1];
    assign bus.rs2_busy     = busy_q[bus.chk_rs2];
    assign bus.fwd_rs1_hit  = rs1_stage;
    assign bus.fwd_rs2_hit  = rs2_stage;
    assign bus.fwd_rs1_data = rs1_stage ? data_q : '0;
    assign bus.fwd_rs2_data = rs2_stage ? data_q : '0;
`else
    // The register being written this cycle is not yet readable from the file.
    assign bus.rs1_busy = busy_q[bus.chk_rs1] | rs1_stage;
    assign bus.rs2_busy = busy_q[bus.chk_rs2] | rs2_stage;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for regfile_wb_scheduler
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int REGW = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

    regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .REGW(REGW)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.flush = 1'b0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset_n = 1'b0;
        to_pos();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h11;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'h22;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        bus.chk_rs1 = 5'd3; bus.chk_rs2 = 5'd4;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            checks += 4;
            if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", bus.alu_ready); end
            if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", bus.mem_ready); end
            if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.rf_wr_en); end
            if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy: got %b expected 0", bus.rs1_busy); end
            to_pos();
        end
        checks += 2;
        if (bus.rf_destn_reg !== 5'd0) begin errors++; $display("FAIL reset_destn_reg: got %0d expected 0", bus.rf_destn_reg); end
        if (bus.rf_destn_data !== 64'd0) begin errors++; $display("FAIL reset_destn_data: got %0h expected 0", bus.rf_destn_data); end
        idle();
        reset_n = 1'b1;
        to_neg();
        checks++;
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b expected 0", bus.rs1_busy); end
        to_pos();
    endtask

    task automatic test_single_alu();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'hDEAD;
        to_neg();
        checks += 2;
        if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b expected 1", bus.alu_ready); end
        if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL single_mem_ready: got %b expected 0", bus.mem_ready); end
        to_pos();
        idle();
        to_neg();
        checks += 3;
        if (bus.rf_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", bus.rf_wr_en); end
        if (bus.rf_destn_reg !== 5'd5) begin errors++; $display("FAIL single_reg: got %0d expected 5", bus.rf_destn_reg); end
        if (bus.rf_destn_data !== 64'hDEAD) begin errors++; $display("FAIL single_data: got %0h expected dead", bus.rf_destn_data); end
        to_pos();
        to_neg();
        checks++;
        if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_pulse: got %b expected 0", bus.rf_wr_en); end
        to_pos();
    endtask

    task automatic test_contention();
        logic exp_alu;
        logic [REGW-1:0] prev_rd;
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'hA3;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 64'hB4;
        prev_rd = '0;
        for (int i = 0; i < 4; i++) begin
            exp_alu = (i % 2 == 0);
            to_neg();
            checks += 3;
            if (bus.alu_ready !== exp_alu) begin errors++; $display("FAIL contention_alu_%0d: got %b expected %b", i, bus.alu_ready, exp_alu); end
            if (bus.mem_ready !== !exp_alu) begin errors++; $display("FAIL contention_mem_%0d: got %b expected %b", i, bus.mem_ready, !exp_alu); end
            if (i > 0 && bus.rf_destn_reg !== prev_rd) begin errors++; $display("FAIL contention_wb_%0d: got %0d expected %0d", i, bus.rf_destn_reg, prev_rd); end
            prev_rd = exp_alu ? 5'd3 : 5'd4;
            to_pos();
        end
        idle();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        bus.chk_rs1 = 5'd7; bus.chk_rs2 = 5'd7;
        to_neg();
        checks++;
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_before_issue: got %b expected 0", bus.rs1_busy); end
        to_pos();
        idle();
        for (int i = 0; i < 2; i++) begin
            to_neg();
            checks += 2;
            if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_pending_rs1: got %b expected 1", bus.rs1_busy); end
            if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_pending_rs2: got %b expected 1", bus.rs2_busy); end
            to_pos();
        end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 64'h1234_5678_9ABC_DEF0;
        to_neg();
        checks += 2;
        if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL sb_wb_ready: got %b expected 1", bus.mem_ready); end
        if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_accept_cycle: got %b expected 1", bus.rs1_busy); end
        to_pos();
        idle();
        to_neg();
`ifdef REGFILE_WB_FWD_EN
        checks += 3;
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_stage_busy: got %b expected 0", bus.rs1_busy); end
        if (bus.fwd_rs1_hit !== 1'b1) begin errors++; $display("FAIL sb_fwd_hit: got %b expected 1", bus.fwd_rs1_hit); end
        if (bus.fwd_rs1_data !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL sb_fwd_data: got %0h expected 123456789abcdef0", bus.fwd_rs1_data); end
`else
        checks++;
        if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_stage_busy: got %b expected 1", bus.rs1_busy); end
`endif
        to_pos();
        to_neg();
        checks++;
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_released: got %b expected 0", bus.rs1_busy); end
`ifdef REGFILE_WB_FWD_EN
        checks += 2;
        if (bus.fwd_rs1_hit !== 1'b0) begin errors++; $display("FAIL sb_fwd_hit_off: got %b expected 0", bus.fwd_rs1_hit); end
        if (bus.fwd_rs1_data !== 64'd0) begin errors++; $display("FAIL sb_fwd_data_off: got %0h expected 0", bus.fwd_rs1_data); end
`endif
        to_pos();
    endtask

    task automatic test_set_clear_flush();
        apply_reset();
        bus.chk_rs1 = 5'd9; bus.chk_rs2 = 5'd0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        to_pos();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 64'h99;
        to_pos();
        idle();
        to_pos();
        to_neg();
        checks++;
        if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL setclr_set_wins: got %b expected 1", bus.rs1_busy); end
        to_pos();
        bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 64'h5A5A;
        to_neg();
        checks++;
        if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", bus.mem_ready); end
        to_pos();
        idle();
        to_neg();
        checks += 2;
        if (bus.rf_wr_en !== 1'b1) begin errors++; $display("FAIL flush_write_kept: got %b expected 1", bus.rf_wr_en); end
        if (bus.rf_destn_data !== 64'h5A5A) begin errors++; $display("FAIL flush_write_data: got %0h expected 5a5a", bus.rf_destn_data); end
        to_pos();
        to_neg();
        checks++;
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL flush_cleared: got %b expected 0", bus.rs1_busy); end
        to_pos();
    endtask

    task automatic test_x0();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'hFF;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0;
        to_neg();
        checks++;
        if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", bus.alu_ready); end
        to_pos();
        idle();
        to_neg();
        checks += 2;
        if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_no_write: got %b expected 0", bus.rf_wr_en); end
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", bus.rs1_busy); end
        to_pos();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12; bus.chk_rs1 = 5'd12;
        to_pos();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 64'hC0DE;
        reset_n = 1'b0;
        to_neg();
        checks++;
        if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", bus.alu_ready); end
        to_pos();
        idle();
        reset_n = 1'b1;
        to_neg();
        checks += 2;
        if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en: got %b expected 0", bus.rf_wr_en); end
        if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.rs1_busy); end
        to_pos();
    endtask

    // Reference: per-register busy flags, last-granted requester, one-deep write pipeline.
    task automatic test_random();
        bit [NREG-1:0]   m_busy;
        bit              m_last_mem, m_wen;
        logic [REGW-1:0] m_reg;
        logic [XLEN-1:0] m_data;
        bit              alu_pend, mem_pend, g_alu, g_mem;
        int              alu_wait, mem_wait;
        logic            e1, e2, s1, s2;
        apply_reset();
        m_busy = '0; m_last_mem = 1'b1; m_wen = 1'b0;
        alu_pend = 1'b0; mem_pend = 1'b0; alu_wait = 0; mem_wait = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!alu_pend) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_rd = 5'($urandom_range(0, 7));
                bus.alu_data = {$urandom(), $urandom()};
            end
            if (!mem_pend) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_rd = 5'($urandom_range(0, 7));
                bus.mem_data = {$urandom(), $urandom()};
            end
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd = 5'($urandom_range(0, 7));
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.chk_rs1 = 5'($urandom_range(0, 7));
            bus.chk_rs2 = 5'($urandom_range(0, 7));
            to_neg();
            g_alu = bus.alu_valid && (!bus.mem_valid || m_last_mem);
            g_mem = bus.mem_valid && !g_alu;
            s1 = m_wen && (m_reg == bus.chk_rs1) && (bus.chk_rs1 != 0);
            s2 = m_wen && (m_reg == bus.chk_rs2) && (bus.chk_rs2 != 0);
`ifdef REGFILE_WB_FWD_EN
            e1 = m_busy[bus.chk_rs1];
            e2 = m_busy[bus.chk_rs2];
            checks += 2;
            if (bus.fwd_rs1_hit !== s1) begin errors++; $display("FAIL rnd_fwd1 cyc %0d: got %b expected %b", cyc, bus.fwd_rs1_hit, s1); end
            if (bus.fwd_rs2_data !== (s2 ? m_data : 64'd0)) begin errors++; $display("FAIL rnd_fwd2 cyc %0d: got %0h", cyc, bus.fwd_rs2_data); end
`else
            e1 = m_busy[bus.chk_rs1] | s1;
            e2 = m_busy[bus.chk_rs2] | s2;
`endif
            checks += 5;
            if (bus.alu_ready !== g_alu) begin errors++; $display("FAIL rnd_alu_ready cyc %0d: got %b expected %b", cyc, bus.alu_ready, g_alu); end
            if (bus.mem_ready !== g_mem) begin errors++; $display("FAIL rnd_mem_ready cyc %0d: got %b expected %b", cyc, bus.mem_ready, g_mem); end
            if (bus.rf_wr_en !== m_wen) begin errors++; $display("FAIL rnd_wr_en cyc %0d: got %b expected %b", cyc, bus.rf_wr_en, m_wen); end
            if (bus.rs1_busy !== e1) begin errors++; $display("FAIL rnd_rs1_busy cyc %0d: got %b expected %b", cyc, bus.rs1_busy, e1); end
            if (bus.rs2_busy !== e2) begin errors++; $display("FAIL rnd_rs2_busy cyc %0d: got %b expected %b", cyc, bus.rs2_busy, e2); end
            if (m_wen) begin
                checks++;
                if (bus.rf_destn_reg !== m_reg || bus.rf_destn_data !== m_data) begin
                    errors++; $display("FAIL rnd_write cyc %0d: got r%0d %0h expected r%0d %0h", cyc, bus.rf_destn_reg, bus.rf_destn_data, m_reg, m_data);
                end
            end
            alu_wait = (bus.alu_valid && !g_alu) ? alu_wait + 1 : 0;
            mem_wait = (bus.mem_valid && !g_mem) ? mem_wait + 1 : 0;
            checks++;
            if (alu_wait > 1 || mem_wait > 1) begin errors++; $display("FAIL rnd_starve cyc %0d: waits %0d %0d expected <= 1", cyc, alu_wait, mem_wait); end
            m_wen = 1'b0;
            if (g_alu || g_mem) begin
                m_reg  = g_alu ? bus.alu_rd : bus.mem_rd;
                m_data = g_alu ? bus.alu_data : bus.mem_data;
                m_wen  = (m_reg != 0);
                m_busy[m_reg] = 1'b0;
                m_last_mem = g_mem;
            end
            if (bus.flush) m_busy = '0;
            else if (bus.issue_valid) m_busy[bus.issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
            alu_pend = bus.alu_valid && !g_alu;
            mem_pend = bus.mem_valid && !g_mem;
            to_pos();
        end
        idle();
    endtask

    initial begin
        idle();
        bus.chk_rs1 = '0; bus.chk_rs2 = '0;
        to_pos();
        test_reset();
        test_single_alu();
        test_contention();
        test_scoreboard();
        test_set_clear_flush();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
